// File: rtl/npc_predict_unit_pkg.sv
// npc_pkg: shared definitions for the fetch next-PC unit.
//   - 2-bit branch counter encodings and saturating step helpers
//   - default reset PC
//   - branch_target: PC+4 + (offset << 2), wrapping mod 2^32
package npc_pkg;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == CTR_ST) ? c : c + 2'b01;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == CTR_SNT) ? c : c - 2'b01;
  endfunction

  function automatic logic [31:0] branch_target(input logic [31:0] pc, input logic [31:0] off);
    return pc + 32'd4 + (off << 2);
  endfunction

endpackage

// File: rtl/npc_predict_unit_if.sv
// npc_predict_unit_if: fetch/resolve signal bundle of the next-PC unit.
//   slave  modport: the predict unit (drives Pc, prediction, Flush, Mispred_cnt)
//   master modport: the pipeline side (drives Stall_F and the EX resolve fields)
interface npc_predict_unit_if #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
);
  logic              Stall_F;
  logic [ADDR_W-1:0] Pc;
  logic              Pred_taken;
  logic [ADDR_W-1:0] Pred_target;
  logic              Resolve_valid;
  logic [ADDR_W-1:0] Resolve_pc;
  logic [31:0]       Resolve_off;
  logic              Resolve_taken;
  logic              Resolve_pred;
  logic              Flush;
  logic [CNT_W-1:0]  Mispred_cnt;

  modport slave (
    input  Stall_F, Resolve_valid, Resolve_pc, Resolve_off, Resolve_taken, Resolve_pred,
    output Pc, Pred_taken, Pred_target, Flush, Mispred_cnt
  );

  modport master (
    output Stall_F, Resolve_valid, Resolve_pc, Resolve_off, Resolve_taken, Resolve_pred,
    input  Pc, Pred_taken, Pred_target, Flush, Mispred_cnt
  );
endinterface

// File: rtl/npc_btb.sv
// npc_btb: direct-mapped branch target buffer with 2-bit counters.
//   clk, rst_n      : clock, synchronous active-low reset (valid=0, ctr=WNT)
//   lk_pc           : asynchronous lookup address -> lk_hit, lk_ctr, lk_target
//   upd_en, upd_pc  : resolve-side read-modify-write at the upd_pc index
//   upd_taken       : actual outcome; upd_target: branch target for allocation
module npc_btb
  import npc_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int BTB_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] lk_pc,
  output logic              lk_hit,
  output logic [1:0]        lk_ctr,
  output logic [ADDR_W-1:0] lk_target,
  input  logic              upd_en,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target
);
  localparam int IDX_W = $clog2(BTB_DEPTH);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  logic [BTB_DEPTH-1:0] valid_q;
  logic [1:0]           ctr_q    [BTB_DEPTH];
  logic [TAG_W-1:0]     tag_q    [BTB_DEPTH];
  logic [ADDR_W-1:0]    target_q [BTB_DEPTH];

  logic [IDX_W-1:0] lk_idx, upd_idx;
  logic [TAG_W-1:0] lk_tag, upd_tag;
  logic             upd_hit;

  // Byte-offset bits of a word-aligned PC carry no information.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{lk_pc[1:0], upd_pc[1:0]};

  assign lk_idx  = lk_pc[IDX_W+1:2];
  assign lk_tag  = lk_pc[ADDR_W-1:IDX_W+2];
  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = upd_pc[ADDR_W-1:IDX_W+2];

  assign lk_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign lk_ctr    = ctr_q[lk_idx];
  assign lk_target = target_q[lk_idx];

  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < BTB_DEPTH; i++) ctr_q[i] <= CTR_WNT;
    end else if (upd_en) begin
      if (upd_hit) begin
        ctr_q[upd_idx] <= upd_taken ? sat_inc(ctr_q[upd_idx]) : sat_dec(ctr_q[upd_idx]);
      end else if (upd_taken) begin
        // A taken miss evicts whatever lived at this index.
        valid_q[upd_idx] <= 1'b1;
        ctr_q[upd_idx]   <= CTR_WT;
      end
    end
  end

  // Tag/target need no reset: they are only observed through valid_q.
  always_ff @(posedge clk) begin
    if (rst_n && upd_en && !upd_hit && upd_taken) begin
      tag_q[upd_idx]    <= upd_tag;
      target_q[upd_idx] <= upd_target;
    end
  end

endmodule

// File: rtl/npc_predict_unit.sv
// npc_predict_unit: fetch PC register, BTB-based next-PC prediction and
// misprediction redirect.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : npc_predict_unit_if.slave (Stall_F, Resolve_* in;
//                Pc, Pred_taken, Pred_target, Flush, Mispred_cnt out)
module npc_predict_unit
  import npc_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(DEF_RESET_PC),
  parameter int                BTB_DEPTH = 16,
  parameter int                CNT_W     = 16
) (
  input  logic clk,
  input  logic rst_n,
  npc_predict_unit_if.slave bus
);
  logic [ADDR_W-1:0] pc_q;
  logic [CNT_W-1:0]  mispred_q;
  logic              lk_hit;
  logic [1:0]        lk_ctr;
  logic [ADDR_W-1:0] lk_target;
  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] br_target;
  logic [ADDR_W-1:0] fall_through;
  logic              pred_taken;
  logic              flush;

  npc_btb #(
    .ADDR_W    (ADDR_W),
    .BTB_DEPTH (BTB_DEPTH)
  ) u_btb (
    .clk        (clk),
    .rst_n      (rst_n),
    .lk_pc      (pc_q),
    .lk_hit     (lk_hit),
    .lk_ctr     (lk_ctr),
    .lk_target  (lk_target),
    .upd_en     (bus.Resolve_valid),
    .upd_pc     (bus.Resolve_pc),
    .upd_taken  (bus.Resolve_taken),
    .upd_target (br_target)
  );

  assign pc_plus4     = pc_q + ADDR_W'(4);
  assign fall_through = bus.Resolve_pc + ADDR_W'(4);
  assign br_target    = ADDR_W'(branch_target(32'(bus.Resolve_pc), bus.Resolve_off));

  assign pred_taken = lk_hit && lk_ctr[1];

  // A resolve seen during reset is discarded, so it must not raise Flush.
  assign flush = rst_n && bus.Resolve_valid && (bus.Resolve_taken != bus.Resolve_pred);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else if (flush) begin
      pc_q <= bus.Resolve_taken ? br_target : fall_through;
    end else if (!bus.Stall_F) begin
      pc_q <= pred_taken ? lk_target : pc_plus4;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mispred_q <= '0;
    end else if (flush && (mispred_q != '1)) begin
      mispred_q <= mispred_q + CNT_W'(1);
    end
  end

  assign bus.Pc          = pc_q;
  assign bus.Pred_taken  = pred_taken;
  assign bus.Pred_target = pred_taken ? lk_target : pc_plus4;
  assign bus.Flush       = flush;
  assign bus.Mispred_cnt = mispred_q;

endmodule
